// File: rtl/ce_gen_multi.sv
// ce_gen_multi
// Multi-channel clock-enable generator for the clk_sys domain. Each channel is
// a fractional phase accumulator: the carry out of the accumulator gives the
// rising-phase enable (ce_p). The half-scale crossing gives the paired
// falling-phase enable (ce_n).
// A new increment is held in a per-channel pending register. It is swapped in
// only at a period boundary, so a rate change never shortens or stretches a
// pulse mid-period.
module ce_gen_multi #(
  parameter int                      NUM_CH   = 4,
  parameter int                      ACC_W    = 16,
  parameter logic [NUM_CH*ACC_W-1:0] INIT_INC = {16'h8000, 16'h4000, 16'h2000, 16'h2000}
) (
  input  logic                      clk_sys,
  input  logic                      reset,
  input  logic                      inc_wr,
  input  logic [$clog2(NUM_CH)-1:0] inc_ch,
  input  logic [ACC_W-1:0]          inc_data,
  input  logic [NUM_CH-1:0]         pause,
  input  logic                      sync,
  output logic [NUM_CH-1:0]         ce_p,
  output logic [NUM_CH-1:0]         ce_n,
  output logic [NUM_CH-1:0]         inc_pend
);

  localparam int               CH_W    = $clog2(NUM_CH);
  // Largest legal increment: half of the accumulator range, i.e. f_clk/2.
  // Keeping inc at or below this value means a carry edge and a half-point
  // crossing can never fall on the same cycle.
  localparam logic [ACC_W-1:0] INC_MAX = {1'b1, {(ACC_W-1){1'b0}}};

  // Saturate an increment to INC_MAX.
  function automatic logic [ACC_W-1:0] clamp_inc(input logic [ACC_W-1:0] v);
    return (v > INC_MAX) ? INC_MAX : v;
  endfunction

  // The write data is clamped once and shared by every channel.
  logic [ACC_W-1:0] w_wr_data;
  assign w_wr_data = clamp_inc(inc_data);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] r_inc;
    logic [ACC_W-1:0] r_pend;
    logic             r_pend_vld;
    logic             r_ce_p;
    logic             r_ce_n;

    logic [ACC_W:0]   w_sum;
    logic             w_carry;
    logic             w_half;
    logic             w_wr_hit;
    logic             w_apply;

    // Next-phase arithmetic, boundary detection and write decode for this channel.
    always_comb begin
      w_sum    = {1'b0, r_acc} + {1'b0, r_inc};
      w_carry  = w_sum[ACC_W];
      // Rising through the half-scale point without wrapping.
      w_half   = ~r_acc[ACC_W-1] & w_sum[ACC_W-1] & ~w_sum[ACC_W];
      // An inc_ch value that names no channel matches nothing and is dropped.
      w_wr_hit = inc_wr && (inc_ch == CH_W'(g));
      // A pending rate takes effect at the end of a period. An idle channel
      // (inc==0) has no period end, so it takes the new rate right away.
      w_apply  = r_pend_vld && (w_carry || (r_inc == '0));
    end

    // Accumulator, increment, pending-rate and enable registers.
    // Priority: reset, then sync, then pause, then normal accumulate.
    always_ff @(posedge clk_sys) begin
      if (reset) begin
        r_acc      <= '0;
        r_inc      <= clamp_inc(INIT_INC[g*ACC_W +: ACC_W]);
        r_pend     <= '0;
        r_pend_vld <= 1'b0;
        r_ce_p     <= 1'b0;
        r_ce_n     <= 1'b0;
      end else begin
        if (sync) begin
          // Phase resync overrides pause. It is also a clean boundary for a
          // pending rate.
          r_acc  <= '0;
          r_ce_p <= 1'b0;
          r_ce_n <= 1'b0;
          if (r_pend_vld) begin
            r_inc      <= r_pend;
            r_pend_vld <= 1'b0;
          end
        end else if (pause[g]) begin
          // Phase and rate are frozen, so the channel resumes phase-continuous.
          r_ce_p <= 1'b0;
          r_ce_n <= 1'b0;
        end else begin
          // This edge still accumulates with the old increment. The swap is
          // seen from the next edge on.
          r_acc  <= w_sum[ACC_W-1:0];
          r_ce_p <= w_carry;
          r_ce_n <= w_half;
          if (w_apply) begin
            r_inc      <= r_pend;
            r_pend_vld <= 1'b0;
          end
        end
        // A write on the same edge as a swap wins over the clear. It waits for
        // the next boundary, and a later write simply replaces it.
        if (w_wr_hit) begin
          r_pend     <= w_wr_data;
          r_pend_vld <= 1'b1;
        end
      end
    end

    assign ce_p[g]     = r_ce_p;
    assign ce_n[g]     = r_ce_n;
    assign inc_pend[g] = r_pend_vld;
  end

endmodule
